// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper motor sequencer: opcodes, FSM encoding,
// phase table and instruction layout.
package stepper_pkg;

    localparam int PHASE_W = 4;

    localparam logic [2:0] OP_HALT  = 3'b000;
    localparam logic [2:0] OP_STEPF = 3'b001;
    localparam logic [2:0] OP_STEPR = 3'b010;
    localparam logic [2:0] OP_DELAY = 3'b011;
    localparam logic [2:0] OP_SPEED = 3'b100;
    localparam logic [2:0] OP_JUMP  = 3'b101;

    // EXEC acts on the instruction latched in DECODE, giving the
    // FETCH -> DECODE -> EXEC -> FETCH rhythm for one-byte ops.
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_FETCH2,
        S_OPND,
        S_STEP,
        S_STEP_WAIT,
        S_DLY,
        S_DLY_WAIT,
        S_HALTED
    } state_t;

    // Index 0..3 -> 1001, 1100, 0110, 0011 (entry 0 is the rightmost).
    localparam logic [3:0][PHASE_W-1:0] PHASE_TBL =
        {4'b0011, 4'b0110, 4'b1100, 4'b1001};

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] arg;
    } instr_t;

endpackage

// File: rtl/stepper_phase_gen.sv
// Coil phase generator: 2-bit phase index with a registered coil drive.
import stepper_pkg::*;

module stepper_phase_gen (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               dir,       // 0 = CW (+1), 1 = CCW (-1)
    input  logic               advance,
    input  logic               energise,
    output logic [PHASE_W-1:0] phase
);

    logic [1:0] idx;
    logic [1:0] idx_nxt;

    // Neighbouring index; 2-bit arithmetic gives the mod-4 wrap.
    always_comb idx_nxt = dir ? idx - 2'd1 : idx + 2'd1;

    // Index and coil register; coils stay de-energised until the first start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx   <= 2'd0;
            phase <= '0;
        end else if (advance) begin
            idx   <= idx_nxt;
            phase <= PHASE_TBL[idx_nxt];
        end else if (energise) begin
            phase <= PHASE_TBL[idx];
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Stepper machine-code sequencer: fetches bytes from a sync ROM, decodes
// them and paces coil steps and pauses through an external delay counter.
import stepper_pkg::*;

module step_sequencer #(
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] STEP_DLY0 = 8'd1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic               dly_start,
    output logic               dly_enable,
    output logic [7:0]         dly_value,
    input  logic               dly_done,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               halted
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    instr_t            ir;
    logic [4:0]        steps_left;
    logic [7:0]        step_dly;
    logic [7:0]        dly_val_q;
    logic              dly_start_q;
    logic              done_ok;
    logic              step_adv;
    logic              energise;

    // The counter's done flag is stale in the cycle right after a start.
    assign done_ok = dly_done && !dly_start_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode; dropping run aborts from anywhere.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (run) state_nxt = S_FETCH;
            S_FETCH:     state_nxt = S_DECODE;
            S_DECODE:    state_nxt = S_EXEC;
            S_EXEC: begin
                case (ir.op)
                    OP_HALT:            state_nxt = S_HALTED;
                    OP_STEPF, OP_STEPR: state_nxt = (ir.arg == 5'd0) ? S_FETCH : S_STEP;
                    OP_DELAY, OP_SPEED: state_nxt = S_FETCH2;
                    default:            state_nxt = S_FETCH;
                endcase
            end
            S_FETCH2:    state_nxt = S_OPND;
            S_OPND:      state_nxt = (ir.op == OP_DELAY) ? S_DLY : S_FETCH;
            S_STEP:      state_nxt = S_STEP_WAIT;
            S_STEP_WAIT: if (done_ok) state_nxt = (steps_left == 5'd1) ? S_FETCH : S_STEP;
            S_DLY:       state_nxt = S_DLY_WAIT;
            S_DLY_WAIT:  if (done_ok) state_nxt = S_FETCH;
            S_HALTED:    state_nxt = S_HALTED;
            default:     state_nxt = S_IDLE;
        endcase
        if (!run) state_nxt = S_IDLE;
    end

    // Program counter, instruction/operand latches, step count and speed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc          <= '0;
            ir          <= '0;
            steps_left  <= 5'd0;
            step_dly    <= STEP_DLY0;
            dly_val_q   <= 8'd0;
            dly_start_q <= 1'b0;
        end else begin
            dly_start_q <= dly_start;
            case (state)
                S_IDLE:   pc <= '0;
                S_DECODE: begin
                    ir <= rom_data;
                    pc <= pc + 1'b1;
                end
                S_EXEC: begin
                    if (ir.op == OP_STEPF || ir.op == OP_STEPR) begin
                        steps_left <= ir.arg;
                        dly_val_q  <= step_dly;
                    end
                    if (ir.op == OP_JUMP) pc <= ADDR_W'(ir.arg);
                end
                S_OPND: begin
                    pc <= pc + 1'b1;
                    if (ir.op == OP_SPEED)      step_dly  <= rom_data;
                    else if (ir.op == OP_DELAY) dly_val_q <= rom_data;
                end
                S_STEP_WAIT: if (done_ok) steps_left <= steps_left - 5'd1;
                default: ;
            endcase
        end
    end

    // Output decode; start and advance are held off once run has dropped.
    always_comb begin
        step_adv   = (state == S_STEP) && run;
        energise   = (state == S_IDLE) && run;
        dly_start  = (state == S_STEP || state == S_DLY) && run;
        dly_enable = (state == S_STEP_WAIT || state == S_DLY_WAIT);
        busy       = !(state == S_IDLE || state == S_HALTED);
        halted     = (state == S_HALTED);
        rom_addr   = pc;
        dly_value  = dly_val_q;
    end

    stepper_phase_gen u_phase (
        .clk      (clk),
        .reset_n  (reset_n),
        .dir      (ir.op == OP_STEPR),
        .advance  (step_adv),
        .energise (energise),
        .phase    (phase)
    );

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: sync ROM and delay_counter models, scoreboard
// queues for phases, delay operands and ROM address changes.
module tb_step_sequencer;

    localparam int ADDR_W       = 5;
    localparam int BASIC_PERIOD = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              run = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              dly_start;
    logic              dly_enable;
    logic [7:0]        dly_value;
    logic              dly_done;
    logic [3:0]        phase;
    logic              busy;
    logic              halted;

    step_sequencer #(.ADDR_W(ADDR_W), .STEP_DLY0(8'd1)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .dly_start(dly_start), .dly_enable(dly_enable), .dly_value(dly_value),
        .dly_done(dly_done), .phase(phase), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // Sync ROM
    logic [7:0] rom [32];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Delay counter: value * BASIC_PERIOD enabled cycles; sticky done that
    // drops one cycle after the start pulse.
    logic [7:0] dcnt;
    logic [1:0] dpre;
    logic       dstart_q;
    always @(posedge clk) begin
        if (!reset_n) begin
            dly_done <= 1'b0; dcnt <= 8'd0; dpre <= 2'd0; dstart_q <= 1'b0;
        end else begin
            dstart_q <= dly_start;
            if (dly_start) begin
                dcnt <= dly_value; dpre <= 2'd0;
            end else if (dstart_q) begin
                dly_done <= 1'b0;
            end else if (dly_enable && !dly_done) begin
                if (dpre == 2'(BASIC_PERIOD - 1)) begin
                    dpre <= 2'd0;
                    if (dcnt <= 8'd1) dly_done <= 1'b1;
                    else              dcnt <= dcnt - 8'd1;
                end else begin
                    dpre <= dpre + 2'd1;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard queues
    logic [3:0]        exp_ph_q[$];
    logic [7:0]        exp_dly_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int                start_cyc[$];
    logic              mon_en = 1'b0;
    logic              addr_mon = 1'b0;
    logic [3:0]        last_ph = 4'd0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              prev_start = 1'b0;
    logic              prev_done = 1'b0;
    logic [7:0]        last_start_val = 8'd0;
    int                cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dly_start) begin
                start_cyc.push_back(cyc);
                last_start_val = dly_value;
                if (exp_dly_q.size() != 0) chk("dly_value", dly_value, exp_dly_q.pop_front());
                else                       chk("dly_extra", dly_start, 1'b0);
                if (prev_start)            chk("dly_b2b", dly_start, 1'b0);
            end
            if (dly_enable && dly_done && !prev_done)
                chk("dly_hold", dly_value, last_start_val);
            if (phase !== last_ph) begin
                if (exp_ph_q.size() != 0) chk("phase", phase, exp_ph_q.pop_front());
                else                      chk("phase_extra", phase, last_ph);
            end
            if (addr_mon && rom_addr !== last_addr && exp_addr_q.size() != 0)
                chk("rom_addr", rom_addr, exp_addr_q.pop_front());
        end
        last_ph    = phase;
        last_addr  = rom_addr;
        prev_start = dly_start;
        prev_done  = dly_done;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0; addr_mon = 1'b0; run = 1'b0; reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        exp_ph_q.delete(); exp_dly_q.delete(); exp_addr_q.delete(); start_cyc.delete();
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        chk("start_busy", busy, 1'b1);
        chk("start_addr", rom_addr, 0);
    endtask

    task automatic wait_halt(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (halted) break;
            tick();
        end
        chk("halt_reached", halted, 1'b1);
    endtask

    task automatic wait_enable(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (dly_enable) break;
            tick();
        end
        chk("enable_seen", dly_enable, 1'b1);
    endtask

    task automatic stop_and_drain();
        run = 1'b0;
        tick();
        chk("stop_busy", busy, 1'b0);
        chk("stop_halted", halted, 1'b0);
        tick();
        chk("ph_q_empty", exp_ph_q.size(), 0);
        chk("dly_q_empty", exp_dly_q.size(), 0);
    endtask

    initial begin
        // Reset state with run held high: reset wins.
        run = 1'b1;
        tick(); tick();
        chk("rst_phase", phase, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_start", dly_start, 1'b0);
        chk("rst_enable", dly_enable, 1'b0);
        chk("rst_value", dly_value, 8'd0);

        // 1: reset in the middle of STEP_WAIT
        do_reset();
        rom[0] = 8'h23; rom[1] = 8'h00;   // STEPF 3, HALT
        mon_en = 1'b0;
        run = 1'b1;
        wait_enable(50);
        tick();
        reset_n = 1'b0;
        tick();
        chk("t1_phase", phase, 4'b0000);
        chk("t1_busy", busy, 1'b0);
        chk("t1_enable", dly_enable, 1'b0);
        chk("t1_addr", rom_addr, 0);
        chk("t1_value", dly_value, 8'd0);

        // 2: three CW steps at default speed, then halt
        do_reset();
        rom[0] = 8'h23; rom[1] = 8'h00;
        exp_ph_q = '{4'b1001, 4'b1100, 4'b0110, 4'b0011};
        exp_dly_q = '{8'd1, 8'd1, 8'd1};
        start_run();
        wait_halt(200);
        chk("t2_phase_held", phase, 4'b0011);
        chk("t2_enable", dly_enable, 1'b0);
        chk("t2_starts", start_cyc.size(), 3);
        if (start_cyc.size() == 3) begin
            // STEP + 1 ignored cycle + 3-cycle period + done-seen cycle + STEP
            chk("t2_gap0", start_cyc[1] - start_cyc[0], 6);
            chk("t2_gap1", start_cyc[2] - start_cyc[1], 6);
        end
        stop_and_drain();

        // 3: one CCW step from index 0 wraps to 0011
        do_reset();
        rom[0] = 8'h41; rom[1] = 8'h00;   // STEPR 1, HALT
        exp_ph_q = '{4'b1001, 4'b0011};
        exp_dly_q = '{8'd1};
        start_run();
        wait_halt(100);
        chk("t3_phase", phase, 4'b0011);
        stop_and_drain();

        // 4: SPEED 4, DELAY 2, STEPF 0 (no-op), STEPF 1, HALT
        do_reset();
        rom[0] = 8'h80; rom[1] = 8'd4;
        rom[2] = 8'h60; rom[3] = 8'd2;
        rom[4] = 8'h20; rom[5] = 8'h21; rom[6] = 8'h00;
        exp_ph_q = '{4'b1001, 4'b1100};
        exp_dly_q = '{8'd2, 8'd4};
        start_run();
        wait_halt(300);
        chk("t4_starts", start_cyc.size(), 2);
        chk("t4_phase", phase, 4'b1100);
        stop_and_drain();

        // 5: JUMP 31, STEPF 1 at 31, fall through wraps pc to 0.
        // rom_addr also shows the post-DECODE increment (0 -> 1).
        do_reset();
        rom[0] = 8'hBF; rom[31] = 8'h21;  // JUMP 31 ; 31: STEPF 1
        exp_ph_q = '{4'b1001, 4'b1100};
        exp_dly_q = '{8'd1};
        exp_addr_q = '{5'd1, 5'd31, 5'd0, 5'd1, 5'd31};
        addr_mon = 1'b1;
        start_run();
        for (int i = 0; i < 200; i++) begin
            if (exp_addr_q.size() == 0) break;
            tick();
        end
        chk("t5_addr_seq", exp_addr_q.size(), 0);
        stop_and_drain();

        // 6: drop run during DLY_WAIT, then restart from address 0
        do_reset();
        rom[0] = 8'h60; rom[1] = 8'd5; rom[2] = 8'h00;   // DELAY 5, HALT
        exp_ph_q = '{4'b1001};
        exp_dly_q = '{8'd5};
        start_run();
        wait_enable(50);
        tick(); tick();
        run = 1'b0;
        tick();
        chk("t6_busy", busy, 1'b0);
        chk("t6_enable", dly_enable, 1'b0);
        chk("t6_phase", phase, 4'b1001);
        tick(); tick();
        exp_dly_q.push_back(8'd5);
        start_run();
        wait_halt(200);
        chk("t6_phase_end", phase, 4'b1001);
        stop_and_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
